// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: issues byte/half/word accesses on a req/ack
// data-memory port and stalls the pipeline while an access is outstanding.
module mem_stage_lsu #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        addr_err,
    output logic        bus_err,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_wstrb,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ack
);

    localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state, state_next;
    logic        req, err, f3_bad, misalign, is_half, is_word;
    logic [3:0]  wstrb_new;
    logic [31:0] wdata_new;
    logic [31:0] rshift, ext;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [CW-1:0] cnt;

    // Access legality: stores take precedence when both requests are raised
    always_comb begin
        req     = mem_read | mem_write;
        is_half = (funct3[1:0] == 2'b01);
        is_word = (funct3[1:0] == 2'b10);
        if (mem_write)
            f3_bad = !(funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010);
        else
            f3_bad = (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111);
        misalign = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));
        err      = f3_bad | misalign;
    end

    always_comb begin
        wstrb_new = '0;
        wdata_new = wdata;
        case (funct3[1:0])
            2'b00: begin
                wstrb_new = 4'b0001 << addr[1:0];
                wdata_new = {4{wdata[7:0]}};
            end
            2'b01: begin
                wstrb_new = 4'b0011 << addr[1:0];
                wdata_new = {2{wdata[15:0]}};
            end
            default: wstrb_new = 4'b1111;
        endcase
        if (!mem_write)
            wstrb_new = '0;
    end

    always_comb begin
        rshift = dm_rdata >> {off_q, 3'b000};
        case (f3_q)
            3'b000:  ext = {{24{rshift[7]}}, rshift[7:0]};
            3'b001:  ext = {{16{rshift[15]}}, rshift[15:0]};
            3'b100:  ext = {24'h0, rshift[7:0]};
            3'b101:  ext = {16'h0, rshift[15:0]};
            default: ext = rshift;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (req && !err) state_next = BUSY;
            BUSY: if (dm_ack || cnt == CNT_LAST) state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        stall    = (state == BUSY) || (state == IDLE && req && !err);
        addr_err = (state == IDLE) && req && err;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            dm_req     <= 1'b0;
            dm_we      <= 1'b0;
            dm_addr    <= '0;
            dm_wstrb   <= '0;
            dm_wdata   <= '0;
            load_data  <= '0;
            load_valid <= 1'b0;
            bus_err    <= 1'b0;
            f3_q       <= '0;
            off_q      <= '0;
            cnt        <= '0;
        end else begin
            load_valid <= 1'b0;
            bus_err    <= 1'b0;
            case (state)
                IDLE: if (req && !err) begin
                    dm_req   <= 1'b1;
                    dm_we    <= mem_write;
                    dm_addr  <= {addr[31:2], 2'b00};
                    dm_wstrb <= wstrb_new;
                    dm_wdata <= wdata_new;
                    f3_q     <= funct3;
                    off_q    <= addr[1:0];
                    cnt      <= '0;
                end
                BUSY: if (dm_ack) begin
                    dm_req <= 1'b0;
                    if (!dm_we) begin
                        load_data  <= ext;
                        load_valid <= 1'b1;
                    end
                end else if (cnt == CNT_LAST) begin
                    dm_req  <= 1'b0;
                    bus_err <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: cycle-level access checks plus a load-result scoreboard.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid, addr_err, bus_err;
    logic        dm_req, dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_wstrb;
    logic [31:0] dm_wdata, dm_rdata;
    logic        dm_ack;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] sb_q[$];

    mem_stage_lsu #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
        .addr(addr), .wdata(wdata),
        .stall(stall), .load_data(load_data), .load_valid(load_valid),
        .addr_err(addr_err), .bus_err(bus_err),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wstrb(dm_wstrb), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Scoreboard: every load_valid pulse must match the oldest pending expectation
    always @(negedge clk) begin
        if (rst === 1'b1 && load_valid === 1'b1) begin
            if (sb_q.size() == 0)
                check("lv_unexpected", load_valid, 32'd0);
            else
                check("load_data", load_data, sb_q.pop_front());
        end
    end

    // Called just after a negedge with the DUT in IDLE; returns in the DONE cycle.
    task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rdat, input int waits,
                          input logic [3:0] exp_strb, input logic [31:0] exp_wdata,
                          input logic exp_lv, input logic [31:0] exp_ld);
        int stalls;
        mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
        dm_rdata = rdat; dm_ack = 1'b0;
        if (exp_lv) sb_q.push_back(exp_ld);
        #1;
        stalls = 0;
        if (stall) stalls++;
        check("issue_err", addr_err, 32'd0);
        check("issue_req", dm_req, 32'd0);
        for (int k = 0; k <= waits; k++) begin
            @(negedge clk); #1;
            check("busy_req", dm_req, 32'd1);
            if (stall) stalls++;
            if (k == 0) begin
                check("dm_we", dm_we, wr);
                check("dm_addr", dm_addr, {a[31:2], 2'b00});
                check("dm_wstrb", dm_wstrb, exp_strb);
                if (wr) check("dm_wdata", dm_wdata, exp_wdata);
            end
            if (k == waits) dm_ack = 1'b1;
        end
        @(negedge clk);
        dm_ack = 1'b0;
        #1;
        check("done_req", dm_req, 32'd0);
        check("done_stall", stall, 32'd0);
        check("done_lv", load_valid, exp_lv);
        check("done_buserr", bus_err, 32'd0);
        check("stall_cycles", stalls, waits + 2);
    endtask

    task automatic finish_idle();
        mem_read = 1'b0; mem_write = 1'b0;
        @(negedge clk); #1;
        check("idle_req", dm_req, 32'd0);
        check("idle_lv", load_valid, 32'd0);
        check("idle_stall", stall, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int reqc, bec;
        rst = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = '0;
        addr = '0; wdata = '0; dm_rdata = '0; dm_ack = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_req", dm_req, 32'd0);
        check("rst_we", dm_we, 32'd0);
        check("rst_addr", dm_addr, 32'd0);
        check("rst_strb", dm_wstrb, 32'd0);
        check("rst_ldata", load_data, 32'd0);
        check("rst_stall", stall, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // lb / lbu from the top byte lane
        access(1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF_1234, 0, 4'b0000, 32'h0, 1, 32'hFFFF_FF80);
        finish_idle();
        access(1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF_1234, 0, 4'b0000, 32'h0, 1, 32'h0000_0080);
        finish_idle();

        // Reset during BUSY
        mem_read = 1'b1; funct3 = 3'b010; addr = 32'h40; dm_ack = 1'b0;
        @(negedge clk); #1;
        check("rstmid_pre_req", dm_req, 32'd1);
        rst = 1'b0; mem_read = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rstmid_req", dm_req, 32'd0);
        check("rstmid_stall", stall, 32'd0);
        check("rstmid_ldata", load_data, 32'd0);
        check("rstmid_lv", load_valid, 32'd0);
        check("rstmid_addr", dm_addr, 32'd0);
        dm_ack = 1'b1;
        @(negedge clk);
        dm_ack = 1'b0;
        #1;
        check("stray_ack_req", dm_req, 32'd0);
        check("stray_ack_lv", load_valid, 32'd0);

        access(1, 0, 3'b001, 32'h102, 32'h0, 32'h80FF_1234, 0, 4'b0000, 32'h0, 1, 32'hFFFF_80FF);
        finish_idle();
        access(1, 0, 3'b010, 32'h104, 32'h0, 32'hDEAD_BEEF, 2, 4'b0000, 32'h0, 1, 32'hDEAD_BEEF);
        finish_idle();

        // Stores: sh with 3 wait cycles (ack on the last allowed BUSY cycle), sb
        access(0, 1, 3'b001, 32'h202, 32'hAAAA_BEEF, 32'h0, 3, 4'b1100, 32'hBEEF_BEEF, 0, 32'h0);
        finish_idle();
        access(0, 1, 3'b000, 32'h301, 32'h1234_5678, 32'h0, 1, 4'b0010, 32'h7878_7878, 0, 32'h0);
        finish_idle();
        check("ldata_hold", load_data, 32'hDEAD_BEEF);

        // Misaligned / illegal accesses
        mem_read = 1'b1; funct3 = 3'b010; addr = 32'h6;
        #1;
        check("mis_err", addr_err, 32'd1);
        check("mis_stall", stall, 32'd0);
        @(negedge clk); #1;
        check("mis_req", dm_req, 32'd0);
        funct3 = 3'b011; addr = 32'h8;
        #1;
        check("f3_err", addr_err, 32'd1);
        mem_read = 1'b0; mem_write = 1'b1; funct3 = 3'b100;
        #1;
        check("st_f3_err", addr_err, 32'd1);
        @(negedge clk); #1;
        check("st_f3_req", dm_req, 32'd0);
        finish_idle();

        // Timeout with no ack
        mem_read = 1'b1; funct3 = 3'b010; addr = 32'h20; dm_ack = 1'b0;
        reqc = 0; bec = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (dm_req) reqc++;
            if (bus_err) begin
                bec++;
                check("to_stall_done", stall, 32'd0);
                check("to_req_done", dm_req, 32'd0);
                mem_read = 1'b0;
            end
        end
        check("to_req_cycles", reqc, 32'd4);
        check("to_buserr_pulses", bec, 32'd1);
        check("to_ldata", load_data, 32'hDEAD_BEEF);

        // Write precedence, then back-to-back load
        access(1, 1, 3'b010, 32'h10, 32'h1234_5678, 32'h0, 0, 4'b1111, 32'h1234_5678, 0, 32'h0);
        @(negedge clk);
        access(1, 0, 3'b010, 32'h14, 32'h0, 32'h0BAD_F00D, 0, 4'b0000, 32'h0, 1, 32'h0BAD_F00D);
        finish_idle();

        @(negedge clk);
        check("sb_empty", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
